// File: rtl/snax_simbacore_launch_pkg.sv
// snax_simbacore_launch_pkg: shared types and constants for the SimbaCore launch controller.
package snax_simbacore_launch_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } launch_state_e;
   localparam int CntWidth = 31;
   localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
   localparam int BusyBit = 31;
endpackage

// File: rtl/snax_simbacore_sat_counter.sv
// snax_simbacore_sat_counter: up-counter that sticks at all-ones; clear beats enable.
module snax_simbacore_sat_counter #(
   parameter int Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_o <= '0;
      else if (clr_i) cnt_o <= '0;
      else if (en_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
   end
endmodule

// File: rtl/snax_simbacore_launch_ctrl.sv
// snax_simbacore_launch_ctrl: latches a CSR configuration, pulses start, and
// blocks new configurations until the accelerator reports done.
module snax_simbacore_launch_ctrl
   import snax_simbacore_launch_pkg::*;
#(
   parameter int NumRwCsr = 5,
   parameter int NumRoCsr = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumRwCsr-1:0][31:0] csr_reg_rw_set_i,
   input  logic                      csr_reg_set_valid_i,
   output logic                      csr_reg_set_ready_o,
   output logic [NumRoCsr-1:0][31:0] csr_reg_ro_set_o,
   output logic [NumRwCsr-1:0][31:0] acc_cfg_o,
   output logic                      acc_start_o,
   input  logic                      acc_done_i
);
   localparam logic [1:0] StIdle  = IDLE;
   localparam logic [1:0] StStart = START;
   localparam logic [1:0] StRun   = RUN;

   logic [1:0] state_q, state_d;
   logic accept, busy;
   logic [CntWidth-1:0] cnt;

   assign csr_reg_set_ready_o = state_q == StIdle;
   assign acc_start_o = state_q == StStart;
   assign busy = state_q != StIdle;
   assign accept = csr_reg_set_valid_i && csr_reg_set_ready_o;

   always_comb begin
      state_d = state_q == StIdle  ? (accept ? StStart : StIdle) :
                state_q == StStart ? (acc_done_i ? StIdle : StRun) :
                state_q == StRun   ? (acc_done_i ? StIdle : StRun) : StIdle;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else state_q <= state_d;
   end

   // Config only moves on an accept, so it is frozen for the whole START/RUN window.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_cfg_o <= '0;
      else if (accept) acc_cfg_o <= csr_reg_rw_set_i;
   end

   snax_simbacore_sat_counter #(.Width(CntWidth)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (accept),
      .en_i   (busy),
      .cnt_o  (cnt)
   );

   always_comb begin
      csr_reg_ro_set_o = '0;
      csr_reg_ro_set_o[0][BusyBit] = busy;
      csr_reg_ro_set_o[0][CntWidth-1:0] = cnt;
   end
endmodule

// File: tb/tb_snax_simbacore_launch_ctrl.sv
// tb_snax_simbacore_launch_ctrl: randomized launches checked by a timing scoreboard
// derived from accept/done arithmetic, plus saturation and mid-run reset cases.
module tb_snax_simbacore_launch_ctrl;
   localparam int N = 5;
   localparam int W = N * 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0][31:0] rw_set, cfg;
   logic valid = 1'b0, ready, start, done = 1'b0;
   logic [0:0][31:0] ro;
   int cyc = 0, checks = 0, passes = 0;

   typedef struct {logic [W-1:0] cfg; int len; bit early; int gap;} txn_t;
   typedef struct {int s; int c; int cnt; logic [W-1:0] cfg;} exp_t;
   txn_t tq[$];
   exp_t eq[$];
   exp_t e;
   bit mon_en = 1'b0;
   bit has, exp_s, in_run, exp_d;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   snax_simbacore_launch_ctrl #(.NumRwCsr(N), .NumRoCsr(1)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .csr_reg_rw_set_i    (rw_set),
      .csr_reg_set_valid_i (valid),
      .csr_reg_set_ready_o (ready),
      .csr_reg_ro_set_o    (ro),
      .acc_cfg_o           (cfg),
      .acc_start_o         (start),
      .acc_done_i          (done)
   );

   function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
   endfunction

   function automatic logic [W-1:0] rand_cfg();
      logic [W-1:0] r;
      for (int i = 0; i < N; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_reset();
      chk("reset_ready", W'(ready), W'(1'b1));
      chk("reset_start", W'(start), W'(1'b0));
      chk("reset_cfg", cfg, '0);
      chk("reset_ro", W'(ro[0]), '0);
   endtask

   // Launch k (inputs driven after edge k): start/busy seen at k+1, done driven at k+len,
   // idle with final count seen at k+len+1, which is also the earliest next accept.
   task automatic run_txns();
      int free = cyc, vfrom = cyc, done_at = -1, k;
      while (tq.size() > 0) begin
         @(posedge clk); #1;
         done = (cyc == done_at) || (cyc >= free && $urandom_range(0, 3) == 0);
         if (cyc >= vfrom) begin
            valid = 1'b1;
            rw_set = tq[0].cfg;
            if (cyc >= free) begin
               k = cyc;
               eq.push_back('{s: k + 1, c: k + tq[0].len + 1, cnt: tq[0].len, cfg: tq[0].cfg});
               done_at = k + tq[0].len;
               free = done_at + 1;
               vfrom = tq[0].early ? k + 1 : free + tq[0].gap;
               void'(tq.pop_front());
            end
         end else begin
            valid = 1'b0;
            rw_set = rand_cfg();
         end
      end
      while (cyc <= free) begin
         @(posedge clk); #1;
         valid = 1'b0;
         done = (cyc == done_at);
      end
      chk("scoreboard_drained", W'(eq.size()), '0);
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         has = eq.size() > 0;
         if (has) e = eq[0];
         exp_s = has && cyc == e.s;
         in_run = has && cyc >= e.s && cyc < e.c;
         exp_d = has && cyc == e.c;
         chk("start_pulse", W'(start), W'(exp_s));
         chk("busy_flag", W'(ro[0][31]), W'(in_run));
         chk("ready", W'(ready), W'(!in_run));
         if (in_run) begin
            chk("run_count", W'(ro[0][30:0]), W'(cyc - e.s));
            chk("cfg_stable", cfg, e.cfg);
         end
         if (exp_d) begin
            chk("final_status", W'(ro[0]), W'({1'b0, 31'(e.cnt)}));
            void'(eq.pop_front());
         end
      end
   end

   initial begin
      rw_set = rand_cfg();
      valid = 1'b1;
      done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_reset();
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      valid = 1'b0;
      done = 1'b0;
      mon_en = 1'b1;
      tq.push_back('{cfg: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, len: 4, early: 1'b0, gap: 2});
      tq.push_back('{cfg: rand_cfg(), len: 1, early: 1'b0, gap: 1});
      tq.push_back('{cfg: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, len: 3, early: 1'b1, gap: 0});
      tq.push_back('{cfg: {5{32'd9}}, len: 2, early: 1'b0, gap: 1});
      for (int i = 0; i < 25; i++)
         tq.push_back('{cfg: rand_cfg(), len: int'($urandom_range(1, 6)),
                        early: ($urandom_range(0, 2) == 0), gap: int'($urandom_range(0, 3))});
      run_txns();
      mon_en = 1'b0;

      // Saturation: preload the counter close to its ceiling mid-run.
      @(posedge clk); #1;
      valid = 1'b1;
      rw_set = rand_cfg();
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 force dut.u_cnt.cnt_o = 31'h7FFF_FFFC;
      @(posedge clk);
      #1 release dut.u_cnt.cnt_o;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sat_busy_status", W'(ro[0]), W'(32'hFFFF_FFFF));
      chk("sat_ready_low", W'(ready), W'(1'b0));
      @(posedge clk); #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
      @(negedge clk);
      chk("sat_final_status", W'(ro[0]), W'(32'h7FFF_FFFF));
      chk("sat_ready_high", W'(ready), W'(1'b1));

      // Reset in the middle of a run, then a clean single launch.
      @(posedge clk); #1;
      valid = 1'b1;
      rw_set = rand_cfg();
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_reset();
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      eq.delete();
      mon_en = 1'b1;
      tq.push_back('{cfg: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, len: 4, early: 1'b0, gap: 0});
      run_txns();
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
